// File: rtl/blinds_pos_ctrl.sv
// Roller-blind position controller: button edges set a target level, and the
// committed position {a,b} walks one level per STEP_CYCLES clocks toward it.
module blinds_pos_ctrl #(
    parameter int unsigned STEP_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_close,
    output logic       a,
    output logic       b,
    output logic [1:0] target,
    output logic       moving,
    output logic       done
);

    // state  | meaning
    // IDLE   | pos == target, motor stopped
    // MOVING | pos != target, step counter running
    typedef enum logic {IDLE, MOVING} state_t;

    localparam logic [15:0] STEP_LAST = 16'(STEP_CYCLES - 1);

    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic [1:0]  pos, pos_nx, pos_step, target_nx;
    logic        done_nx;
    logic        up_q, down_q, close_q;
    logic        up_edge, down_edge, close_edge;

    assign up_edge    = btn_up & ~up_q;
    assign down_edge  = btn_down & ~down_q;
    assign close_edge = btn_close & ~close_q;

    always_ff @(posedge clk) begin
        // Edge registers track the buttons even in reset, so a button held
        // through reset is not seen as a fresh press afterwards.
        up_q    <= btn_up;
        down_q  <= btn_down;
        close_q <= btn_close;
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            pos    <= 2'd0;
            target <= 2'd0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            pos    <= pos_nx;
            target <= target_nx;
            done   <= done_nx;
        end
    end

    always_comb begin
        target_nx = target;
        if (close_edge) begin
            target_nx = 2'd0;
        end else if (up_edge && down_edge) begin
            target_nx = target;
        end else if (up_edge) begin
            if (target != 2'd3) target_nx = target + 2'd1;
        end else if (down_edge) begin
            if (target != 2'd0) target_nx = target - 2'd1;
        end
    end

    // A step always heads toward the target as it stood before this cycle's command.
    always_comb begin
        pos_step = pos;
        if (target > pos)      pos_step = pos + 2'd1;
        else if (target < pos) pos_step = pos - 2'd1;
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pos_nx   = pos;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (target_nx != pos) begin
                    state_nx = MOVING;
                    cnt_nx   = '0;
                end
            end
            MOVING: begin
                if (cnt == STEP_LAST) begin
                    pos_nx = pos_step;
                    cnt_nx = '0;
                    if (pos_step == target_nx) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end
                end else if (target_nx == pos) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    done_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    assign moving = (state == MOVING);
    assign a      = pos[1];
    assign b      = pos[0];

endmodule

// File: tb/tb_blinds_pos_ctrl.sv
// Self-checking bench for blinds_pos_ctrl: directed scenarios plus random button
// traffic, all compared against a level/timer reference model.
module tb_blinds_pos_ctrl;

    localparam int STEP = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_close = 1'b0;
    logic       a, b, moving, done;
    logic [1:0] target;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_pos, m_tgt, m_elapsed, m_mov, m_done;
    int m_qu, m_qd, m_qc;

    blinds_pos_ctrl #(.STEP_CYCLES(STEP)) dut (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
        .btn_close(btn_close), .a(a), .b(b), .target(target),
        .moving(moving), .done(done)
    );

    always #5 clk = ~clk;

    // Model: the blind is travelling whenever it is not at the requested level;
    // every STEP clocks of travel it advances one level toward the old request.
    task automatic model_edge(input int u, input int d, input int c, input int r);
        int eu, ed, ec, nt;
        if (r != 0) begin
            m_pos = 0; m_tgt = 0; m_elapsed = 0; m_mov = 0; m_done = 0;
        end else begin
            eu = u & ~m_qu; ed = d & ~m_qd; ec = c & ~m_qc;
            nt = m_tgt;
            if (ec != 0)                nt = 0;
            else if (eu != 0 && ed != 0) nt = m_tgt;
            else if (eu != 0)           nt = (m_tgt + 1 > 3) ? 3 : m_tgt + 1;
            else if (ed != 0)           nt = (m_tgt - 1 < 0) ? 0 : m_tgt - 1;
            m_done = 0;
            if (m_mov == 0) begin
                if (nt != m_pos) begin m_mov = 1; m_elapsed = 0; end
            end else if (m_elapsed + 1 == STEP) begin
                m_pos = m_pos + ((m_tgt > m_pos) ? 1 : -1);
                m_elapsed = 0;
                if (m_pos == nt) begin m_mov = 0; m_done = 1; end
            end else if (nt == m_pos) begin
                m_mov = 0; m_elapsed = 0; m_done = 1;
            end else begin
                m_elapsed++;
            end
            m_tgt = nt;
        end
        m_qu = u; m_qd = d; m_qc = c;
    endtask

    task automatic tick(input logic u, input logic d, input logic c, input logic r);
        btn_up = u; btn_down = d; btn_close = c; rst = r;
        @(posedge clk);
        model_edge(int'(u), int'(d), int'(c), int'(r));
        #1;
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({a, b, target, moving, done} !== 6'b0) begin
            errors++;
            $display("FAIL reset: a,b,target,moving,done=%b required 000000", {a, b, target, moving, done});
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_single_up();
        int dones = 0;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (target !== 2'd1 || moving !== 1'b1 || {a, b} !== 2'b00) begin
            errors++;
            $display("FAIL single_up_start: target=%0d moving=%b ab=%b required 1 1 00", target, moving, {a, b});
        end
        for (int i = 1; i <= STEP; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            if (done === 1'b1) dones++;
            checks++;
            if ({a, b} !== ((i == STEP) ? 2'b01 : 2'b00)) begin
                errors++;
                $display("FAIL single_up_pos: clk %0d ab=%b", i, {a, b});
            end
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (dones != 1 || done !== 1'b0 || moving !== 1'b0) begin
            errors++;
            $display("FAIL single_up_done: pulses=%0d done=%b moving=%b required 1 0 0", dones, done, moving);
        end
    endtask

    task automatic test_up_saturate();
        int dones = 0, steps = 0, n = 0;
        logic [1:0] prev;
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (target !== 2'd3) begin
            errors++;
            $display("FAIL sat_target: target=%0d required 3", target);
        end
        prev = {a, b};
        while (moving === 1'b1 && n < 40) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            n++;
            if (done === 1'b1) dones++;
            if ({a, b} !== prev) begin
                steps++;
                checks++;
                if ({a, b} !== prev + 2'd1) begin
                    errors++;
                    $display("FAIL sat_seq: ab=%b after %b", {a, b}, prev);
                end
                prev = {a, b};
            end
        end
        checks++;
        if (n >= 40 || {a, b} !== 2'b11 || dones != 1 || steps < 2) begin
            errors++;
            $display("FAIL sat_end: n=%0d ab=%b dones=%0d steps=%0d required ab=11 dones=1", n, {a, b}, dones, steps);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (target !== 2'd3 || moving !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL sat_fourth: target=%0d moving=%b done=%b required 3 0 0", target, moving, done);
        end
    endtask

    task automatic test_close();
        logic [1:0] prev;
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (target !== 2'd0 || moving !== 1'b1) begin
            errors++;
            $display("FAIL close_start: target=%0d moving=%b required 0 1", target, moving);
        end
        prev = {a, b};
        for (int i = 1; i <= 3 * STEP; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if ({a, b} !== prev && {a, b} !== prev - 2'd1) begin
                errors++;
                $display("FAIL close_seq: ab=%b after %b", {a, b}, prev);
            end
            prev = {a, b};
            checks++;
            if (moving !== ((i < 3 * STEP) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL close_moving: clk %0d moving=%b", i, moving);
            end
        end
        checks++;
        if ({a, b} !== 2'b00 || done !== 1'b1) begin
            errors++;
            $display("FAIL close_end: ab=%b done=%b required 00 1", {a, b}, done);
        end
    endtask

    task automatic test_reversal();
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (moving !== 1'b1 || {a, b} !== 2'b00) begin
            errors++;
            $display("FAIL rev_pre: moving=%b ab=%b required 1 00", moving, {a, b});
        end
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (target !== 2'd0 || moving !== 1'b0 || done !== 1'b1 || {a, b} !== 2'b00) begin
            errors++;
            $display("FAIL rev_idle: target=%0d moving=%b done=%b ab=%b required 0 0 1 00", target, moving, done, {a, b});
        end
        for (int i = 0; i < 2 * STEP; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if ({a, b} !== 2'b00 || done !== 1'b0) begin
                errors++;
                $display("FAIL rev_after: ab=%b done=%b required 00 0", {a, b}, done);
            end
        end
    endtask

    task automatic test_buttons();
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (target !== 2'd0 || moving !== 1'b0) begin
            errors++;
            $display("FAIL updown_ignored: target=%0d moving=%b required 0 0", target, moving);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (target !== 2'd1 || {a, b} !== 2'b01 || moving !== 1'b0) begin
            errors++;
            $display("FAIL up_held: target=%0d ab=%b moving=%b required 1 01 0", target, {a, b}, moving);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (target !== 2'd0 || moving !== 1'b1) begin
            errors++;
            $display("FAIL close_up: target=%0d moving=%b required 0 1", target, moving);
        end
    endtask

    task automatic test_reset_mid_move();
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({a, b, target, moving, done} !== 6'b0) begin
            errors++;
            $display("FAIL rst_mid: a,b,target,moving,done=%b required 000000", {a, b, target, moving, done});
        end
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0);
            checks++;
            if (target !== 2'd0 || moving !== 1'b0 || {a, b} !== 2'b00) begin
                errors++;
                $display("FAIL rst_release: target=%0d moving=%b ab=%b required 0 0 00", target, moving, {a, b});
            end
        end
    endtask

    task automatic test_random();
        logic u, d, c, r;
        int hold;
        for (int i = 0; i < 600; ) begin
            u = ($urandom_range(0, 9) < 3);
            d = ($urandom_range(0, 9) < 3);
            c = ($urandom_range(0, 19) < 2);
            r = ($urandom_range(0, 99) < 2);
            hold = $urandom_range(1, 6);
            for (int k = 0; k < hold; k++, i++) begin
                tick(u, d, c, r);
                checks++;
                if ({a, b} !== 2'(m_pos) || target !== 2'(m_tgt) ||
                    moving !== 1'(m_mov) || done !== 1'(m_done)) begin
                    errors++;
                    $display("FAIL random cycle %0d: ab=%b target=%0d moving=%b done=%b required ab=%0d target=%0d moving=%0d done=%0d",
                             i, {a, b}, target, moving, done, m_pos, m_tgt, m_mov, m_done);
                end
            end
        end
    endtask

    initial begin
        m_pos = 0; m_tgt = 0; m_elapsed = 0; m_mov = 0; m_done = 0;
        m_qu = 0; m_qd = 0; m_qc = 0;
        test_reset();
        test_single_up();
        test_up_saturate();
        test_close();
        test_reversal();
        test_buttons();
        test_reset_mid_move();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
